// File: rtl/lsu_core.sv
// Multi-cycle load/store unit: one EXU packet in, at most one bus access, one lsu_valid pulse out.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN (adds lsu_misalign output).
module lsu_core #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exu_valid,
    input  logic [108:0]      exu_data,
    output logic              exu_ready,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [WIDTH-1:0]  mem_req_addr,
    output logic              mem_req_wen,
    output logic [WIDTH-1:0]  mem_req_wdata,
    output logic [3:0]        mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [WIDTH-1:0]  mem_resp_rdata,
    input  logic              mem_resp_err,
    output logic              lsu_valid,
    output logic [103:0]      lsu_data,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic              lsu_misalign,
`endif
    output logic [1:0]        dbg_state
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // mem_req_* are held stable while mem_req_valid is high; responses are single-cycle.

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2, DONE = 2'd3} state_t;
    state_t state;

    logic [31:0] in_alu, in_sd;
    logic        in_ren, in_wen, in_rdw, in_mem, in_mis;
    logic [2:0]  in_f3;
    logic [3:0]  st_mask;
    logic [31:0] st_wdata;

    assign in_alu = exu_data[108:77];
    assign in_sd  = exu_data[76:45];
    assign in_ren = exu_data[44];
    assign in_wen = exu_data[43];
    assign in_f3  = exu_data[42:40];
    assign in_rdw = exu_data[39];
    assign in_mem = in_ren | in_wen;

`ifdef LSU_MISALIGN_TRAP_EN
    assign in_mis = in_mem & (((in_f3[1:0] == 2'b01) & in_alu[0]) |
                              ((in_f3[1:0] == 2'b10) & (in_alu[1:0] != 2'b00)));
`else
    assign in_mis = 1'b0;
`endif

    always_comb begin
        st_mask  = 4'hF;
        st_wdata = in_sd;
        case (in_f3[1:0])
            2'b00: begin
                st_mask  = 4'b0001 << in_alu[1:0];
                st_wdata = {4{in_sd[7:0]}};
            end
            2'b01: begin
                st_mask  = 4'b0011 << in_alu[1:0];
                st_wdata = {2{in_sd[15:0]}};
            end
            default: ;
        endcase
    end

    // Fields of the accepted packet kept for the response cycle.
    logic [31:0] h_alu;
    logic [38:0] h_tail;
    logic        h_rdw, h_load;
    logic [2:0]  h_f3;
    logic [1:0]  h_off;
    logic [31:0] shifted, ld_val;

    assign shifted = mem_resp_rdata >> {h_off, 3'b000};

    always_comb begin
        case (h_f3)
            3'b000:  ld_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ld_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ld_val = {24'd0, shifted[7:0]};
            3'b101:  ld_val = {16'd0, shifted[15:0]};
            default: ld_val = shifted;
        endcase
    end

    assign exu_ready = (state == IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wmask <= 4'h0;
            lsu_valid     <= 1'b0;
            lsu_data      <= '0;
            h_alu         <= '0;
            h_tail        <= '0;
            h_rdw         <= 1'b0;
            h_load        <= 1'b0;
            h_f3          <= 3'd0;
            h_off         <= 2'd0;
        end else begin
            lsu_valid <= 1'b0;
            case (state)
                IDLE: if (exu_valid) begin
                    h_alu  <= in_alu;
                    h_tail <= exu_data[38:0];
                    h_rdw  <= in_rdw;
                    h_load <= in_ren & ~in_wen;
                    h_f3   <= in_f3;
                    h_off  <= in_alu[1:0];
                    if (in_mis) begin
                        lsu_data  <= {in_alu, 32'd0, 1'b0, exu_data[38:0]};
                        lsu_valid <= 1'b1;
                        state     <= DONE;
                    end else if (in_mem) begin
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= {in_alu[31:2], 2'b00};
                        mem_req_wen   <= in_wen;
                        mem_req_wdata <= st_wdata;
                        mem_req_wmask <= in_wen ? st_mask : 4'h0;
                        state         <= REQ;
                    end else begin
                        lsu_data  <= {in_alu, 32'd0, in_rdw, exu_data[38:0]};
                        lsu_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                REQ: if (mem_req_ready) begin
                    mem_req_valid <= 1'b0;
                    state         <= RESP;
                end
                RESP: if (mem_resp_valid) begin
                    lsu_data  <= {h_alu, (h_load & ~mem_resp_err) ? ld_val : 32'd0,
                                  h_rdw & ~mem_resp_err, h_tail};
                    lsu_valid <= 1'b1;
                    state     <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // Flag follows lsu_data: updated only when a packet enters DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            lsu_misalign <= 1'b0;
        else if (state == IDLE && exu_valid && (in_mis || !in_mem))
            lsu_misalign <= in_mis;
        else if (state == RESP && mem_resp_valid)
            lsu_misalign <= 1'b0;
    end
`endif
endmodule
